// File: rtl/vga_timing_if.sv
// vga_timing_if: VGA timing bus from the timing generator to the pixel pipeline.
// Signals:
//   horiz_sync, vert_sync  sync pulses (polarity set by the generator)
//   video_on               current pixel lies in the visible region
//   pixel_column/row       current horizontal/vertical count
//   frame_start            one-clock pulse when the count enters (0,0)
// Modports: master = generator side, slave = consumer side.
interface vga_timing_if;
  localparam int unsigned CNT_W = 10;

  logic             horiz_sync;
  logic             vert_sync;
  logic             video_on;
  logic [CNT_W-1:0] pixel_column;
  logic [CNT_W-1:0] pixel_row;
  logic             frame_start;

  modport master (
    output horiz_sync, vert_sync, video_on, pixel_column, pixel_row, frame_start
  );

  modport slave (
    input horiz_sync, vert_sync, video_on, pixel_column, pixel_row, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (sync, video_on, pixel coordinates).
// Ports:
//   clock   system clock
//   reset   synchronous, active-high reset
//   pix_en  pixel-rate enable; the raster advances one pixel per enabled edge
//   vga     timing bus (master side), all signals registered
// Reset parks the count on the last pixel of a frame so the first enabled
// edge afterwards lands on (0,0) and produces a complete first frame.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pix_en,
  vga_timing_if.master vga
);

  localparam int unsigned CNT_W   = 10;
  // One extra bit so region bounds equal to 1024 still compare correctly.
  localparam int unsigned CMP_W   = CNT_W + 1;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  localparam logic [CMP_W-1:0] H_VIS_END  = CMP_W'(H_VISIBLE);
  localparam logic [CMP_W-1:0] H_SYNC_BEG = CMP_W'(H_VISIBLE + H_FRONT);
  localparam logic [CMP_W-1:0] H_SYNC_END = CMP_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CMP_W-1:0] V_VIS_END  = CMP_W'(V_VISIBLE);
  localparam logic [CMP_W-1:0] V_SYNC_BEG = CMP_W'(V_VISIBLE + V_FRONT);
  localparam logic [CMP_W-1:0] V_SYNC_END = CMP_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic             col_wrap;
  logic             row_wrap;
  logic [CNT_W-1:0] col_next;
  logic [CNT_W-1:0] row_next;
  logic [CMP_W-1:0] col_cmp;
  logic [CMP_W-1:0] row_cmp;
  logic             video_on_next;
  logic             hsync_next;
  logic             vsync_next;

  // Next raster position and the qualifiers decoded from it, so the
  // registered outputs carry zero skew relative to the coordinates.
  always_comb begin
    col_wrap = !(vga.pixel_column < H_LAST);
    row_wrap = !(vga.pixel_row < V_LAST);
    col_next = col_wrap ? '0 : vga.pixel_column + CNT_W'(1);
    row_next = vga.pixel_row;
    if (col_wrap) begin
      row_next = row_wrap ? '0 : vga.pixel_row + CNT_W'(1);
    end

    col_cmp       = {1'b0, col_next};
    row_cmp       = {1'b0, row_next};
    video_on_next = (col_cmp < H_VIS_END) && (row_cmp < V_VIS_END);
    hsync_next    = ((col_cmp >= H_SYNC_BEG) && (col_cmp < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    // Row only moves on a column wrap, so vert_sync is inherently line-aligned.
    vsync_next    = ((row_cmp >= V_SYNC_BEG) && (row_cmp < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Output registers; frame_start is a single-clock pulse and self-clears.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga.pixel_column <= H_LAST;
      vga.pixel_row    <= V_LAST;
      vga.video_on     <= 1'b0;
      vga.horiz_sync   <= ~SYNC_POL;
      vga.vert_sync    <= ~SYNC_POL;
      vga.frame_start  <= 1'b0;
    end else if (pix_en) begin
      vga.pixel_column <= col_next;
      vga.pixel_row    <= row_next;
      vga.video_on     <= video_on_next;
      vga.horiz_sync   <= hsync_next;
      vga.vert_sync    <= vsync_next;
      vga.frame_start  <= col_wrap && row_wrap;
    end else begin
      vga.frame_start  <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA display timing for the video pipeline: horizontal/vertical sync, `video_on`, and current pixel row/column.
- Its outputs feed the world-map and icon lookup logic and the color assigner, which consume `video_on` and the pixel coordinates.
- Runs on the system clock; advances one pixel per cycle that the pixel-rate enable is high.
- Default timing is 640x480 @ 60 Hz with a 25 MHz pixel rate.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- SYNC_POL, 0, asserted level of `horiz_sync`/`vert_sync` (0 = active-low)

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel-rate enable; counters advance only on clock edges where high
- horiz_sync  output  1  horizontal sync, level SYNC_POL when asserted
- vert_sync  output  1  vertical sync, level SYNC_POL when asserted
- video_on  output  1  high while the current pixel is in the visible region
- pixel_column  output  10  current horizontal count, 0..H_TOTAL-1
- pixel_row  output  10  current vertical count, 0..V_TOTAL-1
- frame_start  output  1  one-clock pulse when the count enters (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (default 800).
  - V_TOTAL = sum of the V_* parameters (default 525).
  - Both totals must be ≤ 1024.
- Clock and reset: one clock, `clock`; reset is synchronous and active-high, port `reset`; all outputs are registered.
- Reset values: `pixel_column` = H_TOTAL-1 (799), `pixel_row` = V_TOTAL-1 (524), `video_on` = 0, `horiz_sync` = `vert_sync` = ~SYNC_POL (deasserted), `frame_start` = 0. Reset overrides `pix_en`.
- Counting on an edge with `pix_en` = 1:
  - If `pixel_column` < H_TOTAL-1: `pixel_column` +1, `pixel_row` unchanged.
  - Else `pixel_column` → 0, and:
    - if `pixel_row` < V_TOTAL-1: `pixel_row` +1;
    - else `pixel_row` → 0.
- Holding: with `pix_en` = 0, all outputs hold their values, except `frame_start`, which clears.
- All other outputs are registered on the same edge as the counters and reflect the new count (zero skew between coordinates and qualifiers).
- Output decode from the new count (c, r):
  - `video_on` = (c < H_VISIBLE) && (r < V_VISIBLE).
  - `horiz_sync` = SYNC_POL when H_VISIBLE+H_FRONT ≤ c < H_VISIBLE+H_FRONT+H_SYNC (default 656..751), else ~SYNC_POL.
  - `vert_sync` = SYNC_POL when V_VISIBLE+V_FRONT ≤ r < V_VISIBLE+V_FRONT+V_SYNC (default 490..491), else ~SYNC_POL.
  - `frame_start` = 1 for exactly one clock, on the edge where the count moves from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- First frame after reset:
  - The first `pix_en` edge after reset release yields (0,0) with `video_on` = 1 and `frame_start` = 1.
  - The first frame is therefore complete.
- Vertical sync is line-aligned: `vert_sync` changes only on edges where the column wraps to 0.
- Reset mid-frame:
  - Immediately returns to the reset state on the next edge.
  - No partial `frame_start` is produced.
  - The next frame starts cleanly at (0,0).
- `pix_en` held high continuously is legal: one pixel per clock.
- Irregular `pix_en` (gaps) only stretches time; the per-enable pixel sequence is identical.
- Period: `frame_start` pulses are exactly H_TOTAL*V_TOTAL enabled edges apart (420000 by default).
- No combinational path from any input to any output.

Test Plan:
- Reset/startup:
  - Assert `reset` 3 clocks with `pix_en` = 1 → outputs (799, 524), `video_on` = 0, `horiz_sync` = `vert_sync` = 1, `frame_start` = 0.
  - Release `reset` → next edge gives (0,0), `video_on` = 1, `frame_start` = 1.
  - The following edge gives (1,0), `frame_start` = 0.
- Horizontal timing, `pix_en` continuously high from (0,0):
  - `video_on` falls when the column becomes 640.
  - `horiz_sync` goes low when the column becomes 656 and high when it becomes 752.
  - Column wraps 799 → 0 with row incrementing 0 → 1.
- Vertical timing:
  - `video_on` stays 0 for the whole of rows 480..524.
  - `vert_sync` is low exactly for rows 490 and 491 and changes only on column-0 edges.
  - (524, 799) → (0,0) with `frame_start` = 1.
- Enable gaps:
  - Drive `pix_en` as 1 clock high / 3 clocks low (25 MHz from 100 MHz).
  - Outputs hold during low cycles; `frame_start` lasts one clock.
  - 420000 enabled edges between consecutive `frame_start` pulses.
- Reset mid-frame:
  - At (300, 200) assert `reset` 1 clock → (799, 524), `video_on` = 0.
  - Next enabled edge → (0,0) with `frame_start` = 1.
- Parameter override (H_VISIBLE = 8, H_FRONT = 2, H_SYNC = 3, H_BACK = 3, V_VISIBLE = 4, V_FRONT = 1, V_SYNC = 1, V_BACK = 1):
  - `horiz_sync` asserted for columns 10..12.
  - `vert_sync` asserted for row 5.
  - Frame period 16*7 = 112 enabled edges.
